// File: rtl/key_debounce_pulse.sv
// Three-key debounce front end: two-flop synchroniser, per-key stability
// FSM, registered press/release pulses and a priority-encoded key event.

module key_debounce_lane #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_sync,
  output logic key_level,
  output logic rise_evt,
  output logic fall_evt
);
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample matching the current level restarts the count, so only an
  // unbroken run of STABLE_CYCLES differing samples flips the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = 1'b0;
    if (key_sync != logic'(state_q)) begin
      if (cnt_q == CNT_LAST) begin
        state_d = (state_q == IDLE) ? HELD : IDLE;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    key_level = (state_q == HELD);
    rise_evt  = accept && (state_d == HELD);
    fall_evt  = accept && (state_d == IDLE);
  end
endmodule

module key_debounce_pulse #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] key_in,
  output logic [2:0] key_level,
  output logic [2:0] press_pulse,
  output logic [2:0] release_pulse,
  output logic       key_valid,
  output logic [1:0] key_code
);
  localparam int NUM_KEYS = 3;

  logic [NUM_KEYS-1:0] key_meta, key_sync;
  logic [NUM_KEYS-1:0] rise_evt, fall_evt;
  logic [1:0]          code_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  key_debounce_lane #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_lane [NUM_KEYS-1:0] (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_sync (key_sync),
    .key_level(key_level),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Highest key index wins when several presses land together.
  always_comb begin
    code_d = 2'd0;
    if      (rise_evt[2]) code_d = 2'd3;
    else if (rise_evt[1]) code_d = 2'd2;
    else if (rise_evt[0]) code_d = 2'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      key_valid     <= 1'b0;
      key_code      <= 2'd0;
    end else begin
      press_pulse   <= rise_evt;
      release_pulse <= fall_evt;
      key_valid     <= |rise_evt;
      key_code      <= code_d;
    end
  end
endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: window-based reference model checked every
// cycle, plus directed scenarios with hand-computed latencies and codes.

module tb_key_debounce_pulse;
  localparam int S    = 4;
  localparam int HMAX = 8192;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [2:0] key_in  = 3'b000;
  logic [2:0] key_level, press_pulse, release_pulse;
  logic       key_valid;
  logic [1:0] key_code;

  key_debounce_pulse #(.STABLE_CYCLES(S)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .key_valid    (key_valid),
    .key_code     (key_code)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit seen_any = 1'b0;

  logic [2:0] in_h [0:HMAX-1];
  bit         rst_h[0:HMAX-1];

  logic [2:0] m_level = '0, m_press = '0, m_rel = '0;
  logic       m_valid = 1'b0;
  logic [1:0] m_code  = '0;

  // Level the debouncer compares against at edge n: raw input two edges
  // earlier, unless a reset cleared the synchroniser in between.
  function automatic logic [2:0] sync_at(int n);
    if (n < 2) return 3'b000;
    if (rst_h[n-1] || rst_h[n-2]) return 3'b000;
    return in_h[n-2];
  endfunction

  // A key flips at edge n when the last S compared samples all differ from
  // its current level and no reset fell inside that window.
  task automatic model_step(int n);
    logic [2:0] sy;
    bit acc;
    m_press = '0;
    m_rel   = '0;
    if (rst_h[n]) begin
      m_level = '0;
      m_valid = 1'b0;
      m_code  = '0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      acc = (n - S + 1 >= 0);
      for (int m = n - S + 1; m <= n && acc; m++) begin
        sy = sync_at(m);
        if (rst_h[m] || sy[i] == m_level[i]) acc = 1'b0;
      end
      if (acc) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) m_press[i] = 1'b1;
        else            m_rel[i]   = 1'b1;
      end
    end
    m_valid = |m_press;
    m_code  = m_press[2] ? 2'd3 : m_press[1] ? 2'd2 : m_press[0] ? 2'd1 : 2'd0;
  endtask

  always @(posedge sys_clk) begin
    if (cyc < HMAX) begin
      in_h[cyc]  = key_in;
      rst_h[cyc] = sys_rst;
      model_step(cyc);
    end
    #1;
    tests++;
    if ({key_level, press_pulse, release_pulse, key_valid, key_code} !==
        {m_level, m_press, m_rel, m_valid, m_code}) begin
      fails++;
      $display("FAIL cycle%0d: got lvl=%b prs=%b rel=%b vld=%b code=%0d want lvl=%b prs=%b rel=%b vld=%b code=%0d",
               cyc, key_level, press_pulse, release_pulse, key_valid, key_code,
               m_level, m_press, m_rel, m_valid, m_code);
    end
    if ((press_pulse | release_pulse | key_level) != 3'b000 || key_valid) seen_any = 1'b1;
    cyc++;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] k, input logic r);
    @(negedge sys_clk);
    key_in  = k;
    sys_rst = r;
  endtask

  // Waits for a press (rel=0) or release (rel=1) pulse; lat counts edges
  // from the first edge after the call, -1 on timeout.
  task automatic wait_evt(input bit rel, output int lat, output logic [2:0] p,
                          output logic [1:0] c, output logic v);
    lat = -1; p = '0; c = '0; v = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge sys_clk);
      #1;
      if ((rel ? release_pulse : press_pulse) != 3'b000) begin
        lat = t;
        p   = rel ? release_pulse : press_pulse;
        c   = key_code;
        v   = key_valid;
        break;
      end
    end
  endtask

  task automatic count_press(input int n, output int cnt);
    cnt = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge sys_clk);
      #1;
      if (press_pulse != 3'b000) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, extra;
    logic [2:0] p, cur;
    logic [1:0] c;
    logic v, r;
    int mode;

    repeat (3) step(3'b000, 1'b1);
    repeat (8) step(3'b000, 1'b0);
    chk("reset_level", key_level, 0);
    chk("reset_valid", key_valid, 0);

    // Clean press and release of key 0.
    step(3'b001, 1'b0);
    wait_evt(1'b0, lat, p, c, v);
    chk("clean_press_lat", lat, S + 1);
    chk("clean_press_bus", p, 3'b001);
    chk("clean_press_code", c, 1);
    chk("clean_press_valid", v, 1);
    @(posedge sys_clk); #1;
    chk("clean_press_one_cycle", press_pulse, 0);
    repeat (3) step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    wait_evt(1'b1, lat, p, c, v);
    chk("clean_rel_lat", lat, S + 1);
    chk("clean_rel_bus", p, 3'b001);
    chk("clean_rel_no_valid", v, 0);
    repeat (8) step(3'b000, 1'b0);

    // Bounce rejection.
    seen_any = 1'b0;
    repeat (5) begin step(3'b001, 0); step(3'b100, 0); step(3'b000, 0); end
    repeat (4) begin step(3'b010, 0); step(3'b101, 0); step(3'b000, 0); end
    repeat (8) step(3'b000, 1'b0);
    chk("bounce_quiet", seen_any, 0);
    chk("bounce_level", key_level, 0);

    // Bounce then settle.
    repeat (3) begin step(3'b001, 0); step(3'b000, 0); end
    step(3'b001, 1'b0);
    wait_evt(1'b0, lat, p, c, v);
    chk("settle_lat", lat, S + 1);
    count_press(30, extra);
    chk("settle_single", extra, 0);
    repeat (10) step(3'b000, 1'b0);

    // Simultaneous press of keys 1 and 0.
    step(3'b011, 1'b0);
    wait_evt(1'b0, lat, p, c, v);
    chk("simul_bus", p, 3'b011);
    chk("simul_code", c, 2);
    chk("simul_valid", v, 1);
    count_press(50, extra);
    chk("simul_no_repeat", extra, 0);
    repeat (10) step(3'b000, 1'b0);

    // Reset mid-count discards the partial count.
    repeat (4) step(3'b100, 1'b0);
    step(3'b100, 1'b1);
    @(posedge sys_clk); #1;
    chk("midrst_outputs",
        {key_level, press_pulse, release_pulse, key_valid, key_code}, 0);
    step(3'b100, 1'b0);
    wait_evt(1'b0, lat, p, c, v);
    chk("midrst_lat", lat, S + 1);
    chk("midrst_code", c, 3);
    repeat (10) step(3'b000, 1'b0);

    // Reset on the edge that would accept.
    seen_any = 1'b0;
    repeat (5) step(3'b100, 1'b0);
    step(3'b000, 1'b1);
    repeat (12) step(3'b000, 1'b0);
    chk("rstacc_quiet", seen_any, 0);
    chk("rstacc_level", key_level, 0);

    // Randomised bouncing with occasional resets.
    cur = 3'b000;
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) mode = $urandom_range(0, 2);
      for (int i = 0; i < 3; i++) begin
        case (mode)
          0:       if ($urandom_range(0, 1)  == 0) cur[i] = ~cur[i];
          1:       if ($urandom_range(0, 7)  == 0) cur[i] = ~cur[i];
          default: if ($urandom_range(0, 31) == 0) cur[i] = ~cur[i];
        endcase
      end
      r = ($urandom_range(0, 199) == 0);
      step(cur, r);
    end
    repeat (10) step(3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
